// File: rtl/compress_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// compress_scheduler_pkg
// Shared sizes, block types and sequencer state encoding for the scheduler.
// Revision: 1.0
// ============================================================================
package compress_scheduler_pkg;

    localparam int BLOCK_SIZE  = 8;
    localparam int PIX_W       = 8;
    localparam int PIXQ_W      = 9;
    localparam int COEFF_WIDTH = 9;
    localparam int DIM_W       = 8;
    localparam int ADDR_W      = 18;
    localparam int ROW_W       = $clog2(BLOCK_SIZE);

    // Elements are two's-complement; [row][col][bit] with row 0 in the LSBs.
    typedef logic [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][PIXQ_W-1:0]      block_t;
    typedef logic [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][COEFF_WIDTH-1:0] coeff_blk_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4,
        S_DONE  = 3'd5
    } sched_state_e;

    // Unsigned 0..255 to signed -128..127, exact in 9 bits.
    function automatic logic [PIXQ_W-1:0] level_shift(input logic [PIX_W-1:0] pix);
        return {1'b0, pix} - PIXQ_W'(128);
    endfunction

endpackage
`default_nettype wire

// File: rtl/compress_scheduler_if.sv
`default_nettype none
// ============================================================================
// compress_scheduler_if
// Quantized-coefficient block stream towards the entropy coder (valid/ready).
// Revision: 1.0
// ============================================================================
interface compress_scheduler_if;
    import compress_scheduler_pkg::*;

    logic             coeff_valid;
    logic             coeff_ready;
    coeff_blk_t       coeffs_out;
    logic [DIM_W-1:0] blk_x;
    logic [DIM_W-1:0] blk_y;
    logic             last_block;

    modport master (
        output coeff_valid, coeffs_out, blk_x, blk_y, last_block,
        input  coeff_ready
    );

    modport slave (
        input  coeff_valid, coeffs_out, blk_x, blk_y, last_block,
        output coeff_ready
    );

endinterface
`default_nettype wire

// File: rtl/compress_scheduler_fetch.sv
`default_nettype none
// ============================================================================
// compress_scheduler_fetch
// Reads one 8x8 block row by row, level-shifts it and assembles blk_pixels.
// Revision: 1.0
// ============================================================================
module compress_scheduler_fetch
    import compress_scheduler_pkg::*;
(
    input  wire                        clk,
    input  wire                        rst,
    input  wire                        en,
    input  wire [DIM_W-1:0]            blk_x,
    input  wire [DIM_W-1:0]            blk_y,
    input  wire [DIM_W-1:0]            w_lat,
    output logic                       pix_rd_en,
    output logic [ADDR_W-1:0]          pix_rd_addr,
    input  wire [BLOCK_SIZE*PIX_W-1:0] pix_rd_data,
    output block_t                     blk_pixels,
    output logic                       done
);

    // Counts 0..8: reads on 0..7, the extra cycle lets the final row land.
    logic [ROW_W:0]      r_cnt;
    logic                r_rd_d;
    logic [ROW_W-1:0]    r_row_d;
    block_t              r_pixels;
    logic [ADDR_W-1:0]   w_row;

    assign pix_rd_en   = en && !r_cnt[ROW_W];
    assign done        = en &&  r_cnt[ROW_W];
    assign w_row       = ADDR_W'({blk_y, r_cnt[ROW_W-1:0]});
    assign pix_rd_addr = pix_rd_en ? (w_row * ADDR_W'(w_lat) + ADDR_W'(blk_x)) : '0;
    assign blk_pixels  = r_pixels;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_rd_d   <= 1'b0;
            r_row_d  <= '0;
            r_pixels <= '0;
        end else begin
            r_cnt   <= (en && !done) ? r_cnt + 1'b1 : '0;
            r_rd_d  <= pix_rd_en;
            r_row_d <= r_cnt[ROW_W-1:0];
            if (r_rd_d) begin
                for (int c = 0; c < BLOCK_SIZE; c++) begin
                    r_pixels[r_row_d][c] <= level_shift(pix_rd_data[c*PIX_W +: PIX_W]);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/compress_scheduler.sv
`default_nettype none
// ============================================================================
// compress_scheduler
// Raster-order frame sequencer for the 8x8 DCT/quantize datapath, one block in flight.
// Revision: 1.0
// ============================================================================
module compress_scheduler
    import compress_scheduler_pkg::*;
(
    input  wire                        clk,
    input  wire                        rst,
    input  wire                        frame_start,
    input  wire [DIM_W-1:0]            img_w_blocks,
    input  wire [DIM_W-1:0]            img_h_blocks,
    output logic                       pix_rd_en,
    output logic [ADDR_W-1:0]          pix_rd_addr,
    input  wire [BLOCK_SIZE*PIX_W-1:0] pix_rd_data,
    output logic                       blk_start,
    output block_t                     blk_pixels,
    input  wire                        blk_done,
    input  var coeff_blk_t             coeffs_in,
    output logic                       frame_done,
    output logic                       busy,
    compress_scheduler_if.master       coeff_if
);

    localparam int FRAME_W = 2*DIM_W + ROW_W;

    sched_state_e       r_state;
    sched_state_e       w_next;
    logic [DIM_W-1:0]   r_w_lat;
    logic [DIM_W-1:0]   r_h_lat;
    logic [DIM_W-1:0]   r_blk_x;
    logic [DIM_W-1:0]   r_blk_y;
    coeff_blk_t         r_coeffs;
    logic               w_fetch_done;
    logic               w_x_wrap;
    logic               w_last;
    logic               w_accept;
    logic               w_handshake;
    logic [FRAME_W-1:0] w_frame_words;

    assign w_x_wrap      = (r_blk_x == r_w_lat - 1'b1);
    assign w_last        = w_x_wrap && (r_blk_y == r_h_lat - 1'b1);
    assign w_accept      = (r_state == S_IDLE) && frame_start;
    assign w_handshake   = (r_state == S_OUT) && coeff_if.coeff_ready;
    assign w_frame_words = FRAME_W'(img_h_blocks) * FRAME_W'(img_w_blocks) * FRAME_W'(BLOCK_SIZE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (frame_start)
                         w_next = (img_w_blocks == '0 || img_h_blocks == '0) ? S_DONE : S_FETCH;
            S_FETCH: if (w_fetch_done) w_next = S_START;
            S_START: w_next = S_WAIT;
            S_WAIT:  if (blk_done) w_next = S_OUT;
            S_OUT:   if (coeff_if.coeff_ready) w_next = w_last ? S_DONE : S_FETCH;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_w_lat  <= '0;
            r_h_lat  <= '0;
            r_blk_x  <= '0;
            r_blk_y  <= '0;
            r_coeffs <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                assert (32'(w_frame_words) <= (32'(1) << ADDR_W));
                r_w_lat <= img_w_blocks;
                r_h_lat <= img_h_blocks;
                r_blk_x <= '0;
                r_blk_y <= '0;
            end else if (w_handshake) begin
                if (w_x_wrap) begin
                    r_blk_x <= '0;
                    r_blk_y <= r_blk_y + 1'b1;
                end else begin
                    r_blk_x <= r_blk_x + 1'b1;
                end
            end
            if (r_state == S_WAIT && blk_done) r_coeffs <= coeffs_in;
        end
    end

    compress_scheduler_fetch u_fetch (
        .clk         (clk),
        .rst         (rst),
        .en          (r_state == S_FETCH),
        .blk_x       (r_blk_x),
        .blk_y       (r_blk_y),
        .w_lat       (r_w_lat),
        .pix_rd_en   (pix_rd_en),
        .pix_rd_addr (pix_rd_addr),
        .pix_rd_data (pix_rd_data),
        .blk_pixels  (blk_pixels),
        .done        (w_fetch_done)
    );

    assign blk_start            = (r_state == S_START);
    assign frame_done           = (r_state == S_DONE);
    assign busy                 = (r_state == S_FETCH) || (r_state == S_START) ||
                                  (r_state == S_WAIT)  || (r_state == S_OUT);
    assign coeff_if.coeff_valid = (r_state == S_OUT);
    assign coeff_if.coeffs_out  = r_coeffs;
    assign coeff_if.blk_x       = r_blk_x;
    assign coeff_if.blk_y       = r_blk_y;
    assign coeff_if.last_block  = (r_state == S_OUT) && w_last;

endmodule
`default_nettype wire

// File: tb/tb_compress_scheduler.sv
`default_nettype none
// ============================================================================
// tb_compress_scheduler
// Directed and randomized frames against a memory/datapath model of the scheduler.
// Revision: 1.0
// ============================================================================
module tb_compress_scheduler;
    import compress_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [7:0]  img_w_blocks, img_h_blocks;
    logic        pix_rd_en;
    logic [17:0] pix_rd_addr;
    logic [63:0] pix_rd_data;
    logic        blk_start;
    block_t      blk_pixels;
    logic        blk_done;
    coeff_blk_t  coeffs_in;
    logic        frame_done, busy;

    compress_scheduler_if cif();

    compress_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .img_w_blocks (img_w_blocks),
        .img_h_blocks (img_h_blocks),
        .pix_rd_en    (pix_rd_en),
        .pix_rd_addr  (pix_rd_addr),
        .pix_rd_data  (pix_rd_data),
        .blk_start    (blk_start),
        .blk_pixels   (blk_pixels),
        .blk_done     (blk_done),
        .coeffs_in    (coeffs_in),
        .frame_done   (frame_done),
        .busy         (busy),
        .coeff_if     (cif)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [0:4095];
    int unsigned rd_log [$];
    int n_starts = 0;
    int n_done   = 0;
    int n_tests  = 0;
    int n_fail   = 0;

    // Pixel memory with one-cycle read latency plus event logging.
    always @(posedge clk) begin
        pix_rd_data <= pix_rd_en ? mem[pix_rd_addr[11:0]] : 64'h0;
        if (pix_rd_en) rd_log.push_back(32'(pix_rd_addr));
        if (blk_start) n_starts <= n_starts + 1;
        if (frame_done) n_done <= n_done + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [575:0] obs, input logic [575:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [575:0] rand_blk();
        logic [575:0] v;
        for (int i = 0; i < 18; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // mode 0 random, 1 all 128, 2 columns alternating 0/255, 3 pixel = row within block
    task automatic fill_mem(input int mode, input int w);
        for (int a = 0; a < 4096; a++) begin
            logic [63:0] wd;
            case (mode)
                0:       wd = {$urandom, $urandom};
                1:       wd = {8{8'h80}};
                2:       wd = {4{16'hFF00}};
                default: wd = {8{8'((a / w) % 8)}};
            endcase
            mem[a] = wd;
        end
    endtask

    function automatic logic [575:0] exp_block(input int w, input int bx, input int by);
        logic [575:0] b;
        logic [63:0]  wd;
        int           p;
        b = '0;
        for (int r = 0; r < 8; r++) begin
            wd = mem[(by*8 + r)*w + bx];
            for (int c = 0; c < 8; c++) begin
                p = int'(wd[8*c +: 8]) - 128;
                b[(r*8 + c)*9 +: 9] = 9'(p);
            end
        end
        return b;
    endfunction

    task automatic run_frame(input int w, input int h, input int mode, input int stall_blk);
        int           rd_base, starts0, done0, cyc, k;
        logic [575:0] exp_c, obs_a, exp_a;
        logic         early, stable, last;
        fill_mem(mode, w);
        img_w_blocks = 8'(w);
        img_h_blocks = 8'(h);
        frame_start  = 1'b1;
        done0 = n_done;
        tick();
        frame_start  = 1'b0;
        img_w_blocks = 8'($urandom);
        img_h_blocks = 8'($urandom);
        check("busy_rise", busy, 1);
        for (int by = 0; by < h; by++) begin
            for (int bx = 0; bx < w; bx++) begin
                k = by*w + bx;
                rd_base = rd_log.size();
                starts0 = n_starts;
                cyc = 0;
                while (blk_start !== 1'b1 && cyc < 40) begin
                    tick();
                    cyc++;
                end
                check("fetch_cycles", cyc, 9);
                check("rd_count", rd_log.size() - rd_base, 8);
                obs_a = '0;
                exp_a = '0;
                for (int r = 0; r < 8; r++) begin
                    if (rd_base + r < rd_log.size()) obs_a[r*32 +: 32] = rd_log[rd_base + r];
                    exp_a[r*32 +: 32] = 32'((by*8 + r)*w + bx);
                end
                check("rd_addrs", obs_a, exp_a);
                check("blk_pixels", blk_pixels, exp_block(w, bx, by));
                // A new frame request mid-frame must not disturb anything.
                frame_start  = 1'b1;
                img_w_blocks = 8'd0;
                tick();
                frame_start  = 1'b0;
                check("start_pulse_once", n_starts - starts0, 1);
                check("start_low_in_wait", blk_start, 0);
                early = (k != stall_blk) && ($urandom_range(0, 1) == 1);
                repeat ($urandom_range(0, 4)) tick();
                exp_c = rand_blk();
                coeffs_in = exp_c;
                blk_done = 1'b1;
                cif.coeff_ready = early;
                tick();
                blk_done  = 1'b0;
                coeffs_in = rand_blk();
                last = (bx == w-1) && (by == h-1);
                check("valid", cif.coeff_valid, 1);
                check("coeffs_out", cif.coeffs_out, exp_c);
                check("blk_xy", {cif.blk_x, cif.blk_y}, {8'(bx), 8'(by)});
                check("last_block", cif.last_block, last);
                if (k == stall_blk) begin
                    rd_base = rd_log.size();
                    starts0 = n_starts;
                    stable  = 1'b1;
                    blk_done = 1'b1;
                    repeat (20) begin
                        tick();
                        coeffs_in = rand_blk();
                        if (cif.coeff_valid !== 1'b1 || cif.coeffs_out !== exp_c ||
                            cif.blk_x !== 8'(bx) || cif.blk_y !== 8'(by) ||
                            cif.last_block !== last || pix_rd_en !== 1'b0)
                            stable = 1'b0;
                    end
                    blk_done = 1'b0;
                    check("stall_stable", stable, 1);
                    check("stall_no_reads", rd_log.size() - rd_base, 0);
                    check("stall_no_start", n_starts - starts0, 0);
                end
                cif.coeff_ready = 1'b1;
                tick();
                cif.coeff_ready = 1'b0;
                check("valid_drop", cif.coeff_valid, 0);
                if (last) begin
                    check("frame_done", frame_done, 1);
                    check("busy_fall", busy, 0);
                    tick();
                    check("frame_done_pulse", frame_done, 0);
                    check("frame_done_count", n_done - done0, 1);
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd"}, {pix_rd_en, pix_rd_addr, blk_start, frame_done, busy}, 0);
        check({tag, "_pixels"}, blk_pixels, 0);
        check({tag, "_coeffs"}, cif.coeffs_out, 0);
        check({tag, "_outctl"}, {cif.coeff_valid, cif.blk_x, cif.blk_y, cif.last_block}, 0);
    endtask

    initial begin
        int rd_base, done0, cyc;
        rst = 1'b1;
        frame_start = 1'b0;
        img_w_blocks = '0;
        img_h_blocks = '0;
        blk_done = 1'b0;
        coeffs_in = '0;
        cif.coeff_ready = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        run_frame(1, 1, 1, -1);
        run_frame(2, 2, 3, 1);
        run_frame(2, 1, 2, -1);

        // Zero-sized frame: immediate completion, no memory traffic.
        rd_base = rd_log.size();
        done0 = n_done;
        img_w_blocks = 8'd0;
        img_h_blocks = 8'd3;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("zero_dim_done", frame_done, 1);
        check("zero_dim_busy", busy, 0);
        tick();
        check("zero_dim_done_pulse", frame_done, 0);
        check("zero_dim_count", n_done - done0, 1);
        check("zero_dim_no_reads", rd_log.size() - rd_base, 0);

        // Reset while the datapath is working on a block.
        fill_mem(0, 1);
        img_w_blocks = 8'd1;
        img_h_blocks = 8'd1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        cyc = 0;
        while (blk_start !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("abort_reached_start", blk_start, 1);
        tick();
        done0 = n_done;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("abort");
        blk_done = 1'b1;
        coeffs_in = rand_blk();
        tick();
        blk_done = 1'b0;
        check("late_done_valid", {cif.coeff_valid, busy}, 0);
        check("late_done_coeffs", cif.coeffs_out, 0);
        tick();
        check("abort_no_frame_done", n_done - done0, 0);
        run_frame(1, 1, 0, -1);

        repeat (3) run_frame($urandom_range(1, 3), $urandom_range(1, 3), 0, $urandom_range(0, 2));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
